weight_stream_loader: RTL and testbench

//  Write-side counterpart of the per-neuron weight memory controller: it drives that block's

---
 rtl/weight_stream_loader_if.sv | 32 +++
 rtl/weight_stream_loader.sv | 150 +++++++++++++++
 tb/tb_weight_stream_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_loader_if.sv
`default_nettype none
// ============================================================================
// weight_stream_loader_if
// Stream input plus weight-memory write port of the weight stream loader.
// Revision: 1.0
// ============================================================================
interface weight_stream_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic        weight_valid;
    logic [31:0] weight_value;
    logic [31:0] config_layer_no;
    logic [31:0] config_neuron_no;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output s_data, s_valid, abort,
        input  s_ready, weight_valid, weight_value, config_layer_no,
               config_neuron_no, busy, done, error
    );

    modport slave (
        input  s_data, s_valid, abort,
        output s_ready, weight_valid, weight_value, config_layer_no,
               config_neuron_no, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/weight_stream_loader.sv
`default_nettype none
// ============================================================================
// weight_stream_loader
// Turns a header+payload word stream into tagged per-neuron weight writes.
// Revision: 1.0
// ============================================================================
module weight_stream_loader #(
    parameter int DATA_BITS   = 16,
    parameter int NUM_WEIGHTS = 784,
    parameter int MAX_NEURONS = 1024,
    parameter int MAX_LAYERS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    weight_stream_loader_if.slave bus
);
    localparam int WCNT_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam logic [WCNT_W-1:0] C_WCNT_LAST = WCNT_W'(NUM_WEIGHTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]       ncnt_q, ncnt_d;
    logic [15:0]       layer_q, layer_d;
    logic [15:0]       count_q, count_d;
    logic              wv_q, wv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       wval_q, wval_d;
    logic [31:0]       cl_q, cl_d;
    logic [31:0]       cn_q, cn_d;

    logic              w_ready;
    logic              w_accept;
    logic              w_hdr_bad;
    logic [15:0]       w_hdr_layer;
    logic [15:0]       w_hdr_count;

    assign w_ready     = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !bus.abort;
    assign w_accept    = bus.s_valid && w_ready;
    assign w_hdr_layer = bus.s_data[31:16];
    assign w_hdr_count = bus.s_data[15:0];
    assign w_hdr_bad   = (w_hdr_count == 16'd0)
                      || ({16'd0, w_hdr_count} >  $unsigned(MAX_NEURONS))
                      || ({16'd0, w_hdr_layer} >= $unsigned(MAX_LAYERS));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ncnt_d  = ncnt_q;
        layer_d = layer_q;
        count_d = count_q;
        wv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wval_d  = wval_q;
        cl_d    = cl_q;
        cn_d    = cn_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        layer_d = w_hdr_layer;
                        count_d = w_hdr_count;
                        wcnt_d  = '0;
                        ncnt_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    wcnt_d  = '0;
                    ncnt_d  = '0;
                    state_d = S_IDLE;
                end else if (w_accept) begin
                    wv_d   = 1'b1;
                    wval_d = 32'($signed(bus.s_data[DATA_BITS-1:0]));
                    cl_d   = {16'd0, layer_q};
                    cn_d   = {16'd0, ncnt_q};
                    if (wcnt_q == C_WCNT_LAST) begin
                        wcnt_d = '0;
                        // Final weight of the final neuron closes the layer.
                        if (ncnt_q == count_q - 16'd1) begin
                            ncnt_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            ncnt_d = ncnt_q + 16'd1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ncnt_q  <= '0;
            layer_q <= '0;
            count_q <= '0;
            wv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wval_q  <= '0;
            cl_q    <= '0;
            cn_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ncnt_q  <= ncnt_d;
            layer_q <= layer_d;
            count_q <= count_d;
            wv_q    <= wv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wval_q  <= wval_d;
            cl_q    <= cl_d;
            cn_q    <= cn_d;
        end
    end

    assign bus.s_ready          = w_ready;
    assign bus.weight_valid     = wv_q;
    assign bus.weight_value     = wval_q;
    assign bus.config_layer_no  = cl_q;
    assign bus.config_neuron_no = cn_q;
    assign bus.busy             = (state_q == S_LOAD) || (state_q == S_DONE);
    assign bus.done             = done_q;
    assign bus.error            = err_q;
endmodule
`default_nettype wire

// File: tb/tb_weight_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_weight_stream_loader
// Randomised scoreboard bench for weight_stream_loader (4 weights per neuron).
// Revision: 1.0
// ============================================================================
module tb_weight_stream_loader;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    weight_stream_loader_if bus ();

    weight_stream_loader #(
        .DATA_BITS  (16),
        .NUM_WEIGHTS(NW),
        .MAX_NEURONS(1024),
        .MAX_LAYERS (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic [31:0] layer;
        logic [31:0] neuron;
    } wr_t;

    typedef struct {
        int cyc;
        bit is_done;
    } ev_t;

    wr_t exp_w[$];
    ev_t exp_ev[$];

    // Reference model: a layer is simply "total beats expected" and "beats seen".
    bit          m_loading = 0;
    bit          m_in_done = 0;
    logic [31:0] m_layer = '0;
    int          m_total = 0;
    int          m_idx = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // One clock cycle of stimulus; returns whether the beat is consumed.
    task automatic cycle(input bit v, input logic [31:0] d, input bit ab, output bit acc);
        bit          exp_ready;
        int          n;
        logic [15:0] hl;
        logic [15:0] hc;
        @(posedge clk);
        #1;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.abort   = ab;
        n = cyc;
        #0;
        exp_ready = !ab && !m_in_done;
        chk("busy", {31'd0, bus.busy}, {31'd0, m_loading || m_in_done});
        chk("s_ready", {31'd0, bus.s_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        if (m_in_done) begin
            m_in_done = 0;
            exp_ev.push_back('{cyc: n + 1, is_done: 1'b1});
        end else if (m_loading) begin
            if (ab) begin
                m_loading = 0;
            end else if (v) begin
                exp_w.push_back('{cyc: n + 1, val: {{16{d[15]}}, d[15:0]},
                                  layer: m_layer, neuron: m_idx / NW});
                m_idx++;
                if (m_idx == m_total) begin
                    m_loading = 0;
                    m_in_done = 1;
                end
            end
        end else if (acc) begin
            hl = d[31:16];
            hc = d[15:0];
            if (hc == 0 || hc > 1024 || hl >= 8) begin
                exp_ev.push_back('{cyc: n + 1, is_done: 1'b0});
            end else begin
                m_loading = 1;
                m_layer   = {16'd0, hl};
                m_total   = int'(hc) * NW;
                m_idx     = 0;
            end
        end
    endtask

    task automatic send(input logic [31:0] d);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 10) begin
            cycle(1'b1, d, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_timeout: got not-accepted expected accepted for word %h", d);
        end
    endtask

    task automatic gap(input int maxn, input bit allow_abort);
        bit acc;
        repeat ($urandom_range(0, maxn)) begin
            cycle(1'b0, $urandom, allow_abort && ($urandom_range(0, 3) == 0), acc);
        end
    endtask

    // Scoreboard monitor: every cycle, compare strobes and pulses against what is due.
    always @(negedge clk) begin
        if (reset) begin
            bit  w_due;
            bit  d_due;
            bit  e_due;
            wr_t e;
            w_due = (exp_w.size() > 0) && (exp_w[0].cyc == cyc);
            chk("weight_valid", {31'd0, bus.weight_valid}, {31'd0, w_due});
            if (w_due) begin
                e = exp_w.pop_front();
                if (bus.weight_valid) begin
                    chk("weight_value", bus.weight_value, e.val);
                    chk("config_layer_no", bus.config_layer_no, e.layer);
                    chk("config_neuron_no", bus.config_neuron_no, e.neuron);
                end
            end
            d_due = (exp_ev.size() > 0) && (exp_ev[0].cyc == cyc) && exp_ev[0].is_done;
            e_due = (exp_ev.size() > 0) && (exp_ev[0].cyc == cyc) && !exp_ev[0].is_done;
            chk("done", {31'd0, bus.done}, {31'd0, d_due});
            chk("error", {31'd0, bus.error}, {31'd0, e_due});
            if (d_due || e_due) void'(exp_ev.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.abort   = 1'b0;
        #2;
        chk("rst_weight_valid", {31'd0, bus.weight_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_config_layer", bus.config_layer_no, 32'd0);
        #10 reset = 1'b1;

        // Full layer: 3 neurons of 4 weights, words 0..11.
        send(32'h0002_0003);
        for (int k = 0; k < 12; k++) send(k);

        // Sign extension of negative and positive payloads.
        send(32'h0001_0001);
        send(32'h0000_8001);
        send(32'h1234_7FFF);
        send(32'hFFFF_0000);
        send(32'h0000_FFFF);

        // Illegal headers: zero neurons, layer out of range, too many neurons.
        send(32'h0000_0000);
        send(32'h0008_0001);
        send(32'h0000_0401);
        gap(2, 1'b0);

        // Gapped valid during a load.
        send(32'h0004_0001);
        cycle(1'b1, 32'h0000_0011, 1'b0, acc);
        cycle(1'b0, 32'h0000_0099, 1'b0, acc);
        cycle(1'b1, 32'h0000_0022, 1'b0, acc);
        cycle(1'b1, 32'h0000_0033, 1'b0, acc);
        cycle(1'b0, 32'h0000_0099, 1'b0, acc);
        cycle(1'b1, 32'h0000_0044, 1'b0, acc);
        gap(2, 1'b0);

        // Abort after 5 payload beats, then a fresh layer restarting at neuron 0.
        send(32'h0005_0003);
        for (int k = 0; k < 5; k++) send(32'h100 + k);
        cycle(1'b1, 32'h0000_0BAD, 1'b1, acc);
        send(32'h0001_0002);
        for (int k = 0; k < 8; k++) send(32'h200 + k);

        // Asynchronous reset in the middle of a load.
        send(32'h0003_0002);
        for (int k = 0; k < 3; k++) send(32'h8000 + k);
        cycle(1'b1, 32'h0000_0777, 1'b0, acc);
        #2;
        reset = 1'b0;
        exp_w.delete();
        exp_ev.delete();
        m_loading = 0;
        m_in_done = 0;
        #1;
        chk("arst_weight_valid", {31'd0, bus.weight_valid}, 32'd0);
        chk("arst_config_layer", bus.config_layer_no, 32'd0);
        chk("arst_config_neuron", bus.config_neuron_no, 32'd0);
        chk("arst_weight_value", bus.weight_value, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done_error", {30'd0, bus.done, bus.error}, 32'd0);
        @(negedge clk);
        #2;
        bus.s_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("post_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Randomised layers with gaps, aborts and illegal headers.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] lay;
            logic [15:0] cnt;
            lay = 16'($urandom_range(0, 9));
            cnt = ($urandom_range(0, 9) == 0) ? 16'd1025 : 16'($urandom_range(0, 3));
            gap(2, 1'b1);
            send({lay, cnt});
            if (m_loading) begin
                for (int k = 0; k < int'(cnt) * NW; k++) begin
                    if ($urandom_range(0, 29) == 0) begin
                        cycle(1'($urandom_range(0, 1)), $urandom, 1'b1, acc);
                        break;
                    end
                    gap(1, 1'b0);
                    send($urandom);
                end
            end
        end

        gap(0, 1'b0);
        repeat (4) cycle(1'b0, 32'd0, 1'b0, acc);
        @(posedge clk);
        #2;
        chk("pending_writes", exp_w.size(), 32'd0);
        chk("pending_events", exp_ev.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
